// File: rtl/spi_dac_frame_receiver.sv
// SPI mode-0 slave for 16-bit DAC command frames: oversampled on clk, MSB-first deserialiser,
// frame-length check, and a value register updated by write commands.
module spi_dac_frame_receiver #(
  parameter int               FRAME_BITS   = 16,
  parameter int               CMD_BITS     = 4,
  parameter int               DATA_BITS    = 12,
  parameter logic [CMD_BITS-1:0] EXPECTED_CMD = 4'b0011,
  parameter int               SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spi_sck,
  input  logic                 spi_cs,
  input  logic                 spi_mosi,
  output logic [CMD_BITS-1:0]  cmd_out,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 frame_valid,
  output logic                 frame_error,
  output logic [DATA_BITS-1:0] value_out,
  output logic                 busy
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] FLUSH_CNT = CNT_W'(SYNC_STAGES);

  typedef enum logic [1:0] {ARMWAIT, IDLE, RECEIVE, OVERRUN} state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_hist_q, cs_hist_q;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, cs_rise, cs_fall;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [FRAME_BITS-1:0]  shift_q;
  logic [CMD_BITS-1:0]    cmd_q;
  logic [DATA_BITS-1:0]   data_q, value_q;
  logic                   valid_q, error_q, busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_hist_q  <= 1'b0;
      cs_hist_q   <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_hist_q  <= sck_s;
      cs_hist_q   <= cs_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_hist_q;
  assign cs_rise  = cs_s & ~cs_hist_q;
  assign cs_fall  = ~cs_s & cs_hist_q;

  // ARMWAIT lets the synchroniser flush its reset preset before trusting cs=1; otherwise a
  // reset released mid-frame would see a false cs falling edge and capture the tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARMWAIT;
      cnt_q   <= '0;
      shift_q <= '0;
      cmd_q   <= '0;
      data_q  <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        ARMWAIT: begin
          if (cnt_q < FLUSH_CNT) cnt_q <= cnt_q + 1'b1;
          else if (cs_s)         state_q <= IDLE;
        end
        IDLE: begin
          if (cs_fall) begin
            cnt_q   <= '0;
            shift_q <= '0;
            busy_q  <= 1'b1;
            state_q <= RECEIVE;
          end
        end
        RECEIVE: begin
          if (cs_rise) begin
            if (cnt_q == FULL_CNT) begin
              cmd_q   <= shift_q[FRAME_BITS-1 -: CMD_BITS];
              data_q  <= shift_q[DATA_BITS-1:0];
              valid_q <= 1'b1;
              if (shift_q[FRAME_BITS-1 -: CMD_BITS] == EXPECTED_CMD)
                value_q <= shift_q[DATA_BITS-1:0];
            end else begin
              error_q <= 1'b1;
            end
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (sck_rise) begin
            if (cnt_q == FULL_CNT) begin
              state_q <= OVERRUN;
            end else begin
              shift_q <= {shift_q[FRAME_BITS-2:0], mosi_s};
              cnt_q   <= cnt_q + 1'b1;
            end
          end
        end
        OVERRUN: begin
          if (cs_rise) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= ARMWAIT;
      endcase
    end
  end

  assign cmd_out     = cmd_q;
  assign data_out    = data_q;
  assign value_out   = value_q;
  assign frame_valid = valid_q;
  assign frame_error = error_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_spi_dac_frame_receiver.sv
// Bench for spi_dac_frame_receiver: 100 MHz clk, 1 MHz sck; expected pulses are queued as
// frames are driven and checked by a monitor when the DUT pulses.
module tb_spi_dac_frame_receiver;

  localparam int HALF = 50;
  localparam int LAT  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_sck = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_mosi = 1'b0;
  logic [3:0]  cmd_out;
  logic [11:0] data_out;
  logic        frame_valid;
  logic        frame_error;
  logic [11:0] value_out;
  logic        busy;

  spi_dac_frame_receiver dut (
    .clk        (clk),
    .rst        (rst),
    .spi_sck    (spi_sck),
    .spi_cs     (spi_cs),
    .spi_mosi   (spi_mosi),
    .cmd_out    (cmd_out),
    .data_out   (data_out),
    .frame_valid(frame_valid),
    .frame_error(frame_error),
    .value_out  (value_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          err;
    logic [3:0]  cmd;
    logic [11:0] data;
    logic [11:0] value;
    int          rise;
  } exp_t;

  exp_t        exp_q[$];
  logic [3:0]  m_cmd   = '0;
  logic [11:0] m_data  = '0;
  logic [11:0] m_value = '0;
  int          ncmp = 0;
  int          nfail = 0;

  always @(negedge clk) begin
    exp_t e;
    if (frame_valid || frame_error) begin
      ncmp++;
      if (exp_q.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_pulse: got valid=%0b error=%0b at cycle %0d, want no pulse",
                 frame_valid, frame_error, cyc);
      end else begin
        e = exp_q.pop_front();
        if (frame_valid !== !e.err || frame_error !== e.err || cmd_out !== e.cmd ||
            data_out !== e.data || value_out !== e.value || (cyc - e.rise) != LAT) begin
          nfail++;
          $display("FAIL frame_pulse: got valid=%0b error=%0b cmd=%h data=%h value=%h lat=%0d, want valid=%0b error=%0b cmd=%h data=%h value=%h lat=%0d",
                   frame_valid, frame_error, cmd_out, data_out, value_out, cyc - e.rise,
                   !e.err, e.err, e.cmd, e.data, e.value, LAT);
        end
      end
    end
  end

  task automatic waitc(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    waitc(HALF);
  endtask

  task automatic send_bit(input logic b);
    spi_mosi = b;
    waitc(HALF);
    spi_sck = 1'b1;
    waitc(HALF);
    spi_sck = 1'b0;
  endtask

  // kind: 0 = no pulse expected, 1 = good frame carrying w, 2 = bad frame
  task automatic cs_high(input int kind, input logic [15:0] w, input int gap);
    exp_t e;
    waitc(HALF);
    spi_cs = 1'b1;
    if (kind == 1) begin
      m_cmd  = w[15:12];
      m_data = w[11:0];
      if (w[15:12] == 4'h3) m_value = w[11:0];
    end
    e.err = (kind == 2); e.cmd = m_cmd; e.data = m_data; e.value = m_value; e.rise = cyc;
    if (kind != 0) exp_q.push_back(e);
    waitc(gap);
  endtask

  task automatic spi_frame(input logic [15:0] w, input int nbits, input int gap);
    cs_low();
    for (int i = 0; i < nbits; i++) send_bit(i < 16 ? w[15 - i] : 1'b0);
    cs_high(nbits == 16 ? 1 : 2, w, gap);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    waitc(3);
    ncmp += 6;
    if (cmd_out !== 4'h0)    begin nfail++; $display("FAIL reset_cmd: got %h want 0", cmd_out); end
    if (data_out !== 12'h0)  begin nfail++; $display("FAIL reset_data: got %h want 0", data_out); end
    if (value_out !== 12'h0) begin nfail++; $display("FAIL reset_value: got %h want 0", value_out); end
    if (frame_valid !== 1'b0) begin nfail++; $display("FAIL reset_valid: got %b want 0", frame_valid); end
    if (frame_error !== 1'b0) begin nfail++; $display("FAIL reset_error: got %b want 0", frame_error); end
    if (busy !== 1'b0)       begin nfail++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    waitc(10);
  endtask

  task automatic test_write_cmd();
    cs_low();
    for (int i = 0; i < 8; i++) send_bit(1'(16'h3ABC >> (15 - i)));
    ncmp++;
    if (busy !== 1'b1) begin nfail++; $display("FAIL busy_receive: got %b want 1", busy); end
    for (int i = 8; i < 16; i++) send_bit(1'(16'h3ABC >> (15 - i)));
    cs_high(1, 16'h3ABC, 20);
    ncmp += 2;
    if (exp_q.size() != 0) begin nfail++; $display("FAIL write_pending: got %0d want 0", exp_q.size()); end
    if (value_out !== 12'hABC) begin nfail++; $display("FAIL write_value: got %h want abc", value_out); end
  endtask

  task automatic test_other_cmd();
    spi_frame(16'h1123, 16, 20);
    ncmp += 2;
    if (exp_q.size() != 0) begin nfail++; $display("FAIL other_pending: got %0d want 0", exp_q.size()); end
    if (value_out !== 12'hABC) begin nfail++; $display("FAIL other_value: got %h want abc", value_out); end
  endtask

  task automatic test_short_frame();
    spi_frame(16'h3FFF, 15, 20);
    ncmp += 2;
    if (exp_q.size() != 0) begin nfail++; $display("FAIL short_pending: got %0d want 0", exp_q.size()); end
    if (data_out !== 12'h123) begin nfail++; $display("FAIL short_data: got %h want 123", data_out); end
  endtask

  task automatic test_overrun();
    cs_low();
    for (int i = 0; i < 17; i++) send_bit(i < 16 ? 1'(16'h3ABC >> (15 - i)) : 1'b1);
    waitc(5);
    ncmp++;
    if (busy !== 1'b1) begin nfail++; $display("FAIL overrun_busy: got %b want 1", busy); end
    cs_high(2, 16'h0, 20);
    ncmp += 3;
    if (busy !== 1'b0) begin nfail++; $display("FAIL overrun_idle: got %b want 0", busy); end
    if (exp_q.size() != 0) begin nfail++; $display("FAIL overrun_pending: got %0d want 0", exp_q.size()); end
    if (cmd_out !== 4'h1) begin nfail++; $display("FAIL overrun_cmd: got %h want 1", cmd_out); end
  endtask

  task automatic test_reset_midframe();
    cs_low();
    for (int i = 0; i < 8; i++) send_bit(1'(16'h3555 >> (15 - i)));
    rst = 1'b1;
    waitc(1);
    rst = 1'b0;
    m_cmd = '0; m_data = '0; m_value = '0;
    for (int i = 8; i < 16; i++) send_bit(1'(16'h3555 >> (15 - i)));
    ncmp += 2;
    if (busy !== 1'b0) begin nfail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    if (value_out !== 12'h0) begin nfail++; $display("FAIL midrst_value: got %h want 0", value_out); end
    cs_high(0, 16'h0, 20);
    spi_frame(16'h3008, 16, 20);
    ncmp += 2;
    if (exp_q.size() != 0) begin nfail++; $display("FAIL midrst_pending: got %0d want 0", exp_q.size()); end
    if (value_out !== 12'h008) begin nfail++; $display("FAIL midrst_value2: got %h want 008", value_out); end
  endtask

  task automatic test_back_to_back();
    spi_frame(16'h3001, 16, 5);
    spi_frame(16'h3FFE, 16, 20);
    ncmp += 2;
    if (exp_q.size() != 0) begin nfail++; $display("FAIL b2b_pending: got %0d want 0", exp_q.size()); end
    if (value_out !== 12'hFFE) begin nfail++; $display("FAIL b2b_value: got %h want ffe", value_out); end
  endtask

  initial begin
    test_reset();
    test_write_cmd();
    test_other_cmd();
    test_short_frame();
    test_overrun();
    test_reset_midframe();
    test_back_to_back();
    waitc(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/spi_dac_frame_receiver.md
Name: spi_dac_frame_receiver

Overview:
- SPI slave (mode 0) that receives the 16-bit DAC command frames produced by the DDS DAC transmitter.
- Oversamples spi_sck, spi_cs and spi_mosi on a fast system clock, deserialises each frame MSB-first and splits it into a 4-bit command and 12-bit data.
- Validates frame length and publishes the data of accepted write commands.
- Serves as the on-chip loopback/monitor of the DAC link and as the receive end for a second board.

Parameters:
- FRAME_BITS, 16, total bits per frame.
- CMD_BITS, 4, command field width (frame MSBs).
- DATA_BITS, 12, data field width (frame LSBs); CMD_BITS+DATA_BITS must equal FRAME_BITS.
- EXPECTED_CMD, 4'b0011, command code that updates value_out.
- SYNC_STAGES, 2, synchroniser flops per SPI input (minimum 2).

Ports:
- clk, input, 1, system clock; must be at least 8x the spi_sck frequency.
- rst, input, 1, reset; synchronous, active-high.
- spi_sck, input, 1, SPI clock, idle low, asynchronous to clk.
- spi_cs, input, 1, chip select, active low, asynchronous.
- spi_mosi, input, 1, serial data, asynchronous.
- cmd_out, output, CMD_BITS, command of the last good frame.
- data_out, output, DATA_BITS, data of the last good frame.
- frame_valid, output, 1, one-cycle pulse when a good frame completes.
- frame_error, output, 1, one-cycle pulse when a bad frame completes.
- value_out, output, DATA_BITS, data of the last good frame whose command equals EXPECTED_CMD.
- busy, output, 1, high while in RECEIVE or OVERRUN.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - Outputs: cmd_out=0, data_out=0, value_out=0, frame_valid=0, frame_error=0, busy=0.
  - Internal: shift register=0, bit counter=0, state=ARMWAIT, all synchroniser and edge-history flops=1 for cs and 0 for sck and mosi.
- Synchronisation and edge detection:
  - Each input passes through a SYNC_STAGES flop chain.
  - Edges are detected by comparing the last sync stage with one history flop.
  - Only synchronised signals are used by the logic.
- Data sampling: MOSI is sampled on a detected sck rising edge (the transmitter changes MOSI on the falling edge) and shifted in LSB-side, so the first bit received ends up as the frame MSB.
- State ARMWAIT:
  - Entered on reset; ignores all traffic until synchronised cs=1, then goes to IDLE.
  - Prevents capturing a partial frame when reset is released mid-frame.
- State IDLE: on a cs falling edge, clear the counter and shift register and go to RECEIVE.
- State RECEIVE:
  - Each sck rising edge shifts in one bit and increments the counter.
  - If the counter is already FRAME_BITS when another rising edge arrives, go to OVERRUN.
  - On a cs rising edge:
    - If counter == FRAME_BITS: load cmd_out and data_out from the shift register, pulse frame_valid, and load value_out from the data field if the command equals EXPECTED_CMD.
    - Otherwise pulse frame_error.
    - In both cases go to IDLE.
- State OVERRUN: ignore sck; on a cs rising edge, pulse frame_error and go to IDLE.
- Simultaneous events:
  - A cs rising edge and an sck rising edge detected in the same cycle: cs wins and the sck edge is discarded.
  - A cs falling edge and an sck rising edge in the same cycle: the sck edge is discarded (no bit is counted).
- Latency: counting the clk edge that first captures spi_cs=1 as edge 0, frame_valid or frame_error is high during the single cycle following edge SYNC_STAGES.
- Output stability:
  - cmd_out, data_out and value_out hold their values between updates.
  - frame_valid and frame_error never assert together and never exceed one cycle.
- Frame gaps: back-to-back frames are legal with cs high for at least 4 clk cycles between them.
- Widths: the bit counter is wide enough to hold FRAME_BITS (5 bits at default) and saturates in OVERRUN.

Test Plan:
- Send frame 0x3ABC (sck 1 MHz, clk 100 MHz) -> one frame_valid pulse at the specified latency; cmd_out=4'h3, data_out=12'hABC, value_out=12'hABC, frame_error never high.
- After the previous frame, send 0x1123 -> frame_valid pulses; cmd_out=4'h1, data_out=12'h123, value_out stays 12'hABC.
- Send only 15 clocked bits of 0x3FFF, then raise cs -> frame_error pulses once; frame_valid stays 0; cmd_out, data_out and value_out unchanged.
- Send 17 sck pulses inside one cs-low window -> busy high until cs rises, then frame_error pulses once; no output change.
- Assert rst for 1 cycle after bit 7 of frame 0x3555 with cs still low, then finish the frame -> no valid or error pulse for it; the next full frame 0x3008 gives value_out=12'h008.
- Two back-to-back frames 0x3001 and 0x3FFE with a 5-cycle cs-high gap -> two frame_valid pulses; value_out ends at 12'hFFE.
